// File: rtl/add_32.sv
// 32-bit adder built from eight 4-bit carry-lookahead groups plus a second-level
// group-carry lookahead; sum and status flags are registered (one cycle latency).
module add_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        in_valid,
  output logic [31:0] Q,
  output logic        cout,
  output logic        ovf,
  output logic        zero,
  output logic        out_valid
);

  logic [31:0] bit_g;
  logic [31:0] bit_p;
  logic [31:0] bit_c;
  logic [31:0] sum;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [8:0]  grp_c;

  assign bit_g = A & B;
  assign bit_p = A ^ B;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_grp
      logic [3:0] g;
      logic [3:0] p;
      logic       cin;

      assign g   = bit_g[4*gi +: 4];
      assign p   = bit_p[4*gi +: 4];
      assign cin = grp_c[gi];

      assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                       | (p[3] & p[2] & p[1] & g[0]);
      assign grp_p[gi] = &p;

      assign bit_c[4*gi]     = cin;
      assign bit_c[4*gi + 1] = g[0] | (p[0] & cin);
      assign bit_c[4*gi + 2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      assign bit_c[4*gi + 3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                             | (p[2] & p[1] & p[0] & cin);
    end
  endgenerate

  // Each group carry is a flat OR of products of group G/P terms (no chaining
  // through grp_c); the carry-in at bit 0 is zero, so no P-chain/cin term exists.
  always_comb begin
    logic term;
    logic acc;
    grp_c = '0;
    term  = 1'b0;
    acc   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      acc = 1'b0;
      for (int j = 0; j <= k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m <= k; m++) begin
          term = term & grp_p[m];
        end
        acc = acc | term;
      end
      grp_c[k+1] = acc;
    end
  end

  assign sum = bit_p ^ bit_c;

  logic [31:0] q_q, q_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;
  logic        valid_q, valid_d;

  always_comb begin
    q_d     = q_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    valid_d = in_valid;
    if (in_valid) begin
      q_d    = sum;
      cout_d = grp_c[8];
      ovf_d  = (A[31] == B[31]) && (sum[31] != A[31]);
      zero_d = (sum == 32'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= 32'd0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign Q         = q_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_add_32.sv
// Randomized and directed bench for add_32 against an arithmetic reference model.
module tb_add_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic        in_valid;
  logic [31:0] Q;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q;
  logic        exp_cout;
  logic        exp_ovf;
  logic        exp_zero;
  logic        exp_valid;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        co;
    logic        ov;
  } vec_t;

  add_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .Q         (Q),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q     = 32'd0;
    exp_cout  = 1'b0;
    exp_ovf   = 1'b0;
    exp_zero  = 1'b1;
    exp_valid = 1'b0;
  endtask

  // Reference: plain 33-bit unsigned sum and a wide signed sum for overflow.
  task automatic model_step(input logic [31:0] a, input logic [31:0] b, input logic v);
    logic [32:0] s;
    longint      ss;
    exp_valid = v;
    if (v) begin
      s        = {1'b0, a} + {1'b0, b};
      ss       = longint'($signed(a)) + longint'($signed(b));
      exp_q    = s[31:0];
      exp_cout = s[32];
      exp_ovf  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      exp_zero = (s[31:0] == 32'd0);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},     64'(Q),         64'(exp_q));
    check({tag, ".cout"},  64'(cout),      64'(exp_cout));
    check({tag, ".ovf"},   64'(ovf),       64'(exp_ovf));
    check({tag, ".zero"},  64'(zero),      64'(exp_zero));
    check({tag, ".valid"}, 64'(out_valid), 64'(exp_valid));
  endtask

  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic v);
    @(negedge clk);
    A        = a;
    B        = b;
    in_valid = v;
    @(posedge clk);
    #1;
    model_step(a, b, v);
    check_all(tag);
    $display("txn %s a=%h b=%h v=%b -> q=%h cout=%b ovf=%b zero=%b ov=%b",
             tag, a, b, v, Q, cout, ovf, zero, out_valid);
  endtask

  vec_t dir_vecs[7];

  initial begin
    dir_vecs[0] = '{32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0};
    dir_vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    dir_vecs[2] = '{32'h12345678, 32'h87654321, 32'h99999999, 1'b0, 1'b0};
    dir_vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    dir_vecs[4] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
    dir_vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0};
    dir_vecs[6] = '{32'h0F0F0F0F, 32'hF0F0F0F1, 32'h00000000, 1'b1, 1'b0};

    rst_n    = 1'b0;
    A        = $urandom;
    B        = $urandom;
    in_valid = 1'b1;
    model_reset();

    // Reset held with live operands: outputs must stay at reset values.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A = $urandom;
      B = $urandom;
      check_all("reset_hold");
      $display("txn reset_hold q=%h zero=%b ov=%b", Q, zero, out_valid);
    end

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    apply("first_zero", 32'd0, 32'd0, 1'b1);
    check("first_zero.spec_valid", 64'(out_valid), 64'd1);
    check("first_zero.spec_zero",  64'(zero),      64'd1);

    for (int i = 0; i < 7; i++) begin
      apply($sformatf("dir%0d", i), dir_vecs[i].a, dir_vecs[i].b, 1'b1);
      check($sformatf("dir%0d.spec_q", i),    64'(Q),    64'(dir_vecs[i].q));
      check($sformatf("dir%0d.spec_cout", i), 64'(cout), 64'(dir_vecs[i].co));
      check($sformatf("dir%0d.spec_ovf", i),  64'(ovf),  64'(dir_vecs[i].ov));
      check($sformatf("dir%0d.spec_zero", i), 64'(zero), 64'(dir_vecs[i].q == 32'd0));
    end

    // Three back-to-back operations, then idle cycles with changing operands.
    apply("b2b0", 32'h00000010, 32'h00000020, 1'b1);
    apply("b2b1", 32'h00000100, 32'h00000200, 1'b1);
    apply("b2b2", 32'h00001000, 32'h00002000, 1'b1);
    apply("idle0", $urandom, $urandom, 1'b0);
    check("idle0.spec_q", 64'(Q), 64'h00003000);
    apply("idle1", $urandom, $urandom, 1'b0);
    check("idle1.spec_q", 64'(Q), 64'h00003000);

    // Reset asserted between edges with a valid operation pending.
    apply("pre_rst", 32'h11111111, 32'h22222222, 1'b1);
    @(negedge clk);
    A        = 32'h00000005;
    B        = 32'h00000006;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst_async");
    $display("txn midrst_async q=%h zero=%b ov=%b", Q, zero, out_valid);
    @(posedge clk);
    #1;
    check_all("midrst_edge");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    model_step(A, B, 1'b0);
    check_all("midrst_release");
    $display("txn midrst_release q=%h zero=%b ov=%b", Q, zero, out_valid);

    for (int i = 0; i < 10000; i++) begin
      apply($sformatf("rnd%0d", i), $urandom, $urandom, ($urandom_range(0, 9) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
